word_unpacker: RTL and testbench

//   Takes a packed multi-byte word, e.g. {X, {2{A}}} built by the packing logic.

---
 rtl/word_unpacker_pkg.sv | 27 ++
 rtl/word_unpacker_acc.sv | 50 +++++
 rtl/word_unpacker.sv | 128 ++++++++++++
 tb/tb_word_unpacker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/word_unpacker_pkg.sv
// word_unpacker_pkg
//   Shared types and helpers for the word unpacker.
//   BYTE_W         : width of one output byte
//   MAX_BYTES      : widest word the unpacker supports
//   unpack_state_t : FSM states (CSUM only reachable with UNPACK_CHECKSUM_EN)
//   xor_bytes()    : XOR-reduces every byte of a MAX_BYTES-wide vector
package word_unpacker_pkg;

    localparam int BYTE_W    = 8;
    localparam int MAX_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } unpack_state_t;

    function automatic logic [BYTE_W-1:0] xor_bytes(input logic [MAX_BYTES*BYTE_W-1:0] w);
        logic [BYTE_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            r = r ^ w[i*BYTE_W +: BYTE_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/word_unpacker_acc.sv
// byte_xor_acc
//   Running XOR of the data bytes of one word, used as the trailing checksum
//   byte. Only compiled when UNPACK_CHECKSUM_EN is defined, since it is only
//   instantiated in that build.
//   clk   in  : system clock, rising edge
//   rst_n in  : synchronous reset, active-low (clears acc)
//   clr   in  : clear accumulator (word accepted)
//   en    in  : fold d into the accumulator (data byte transferred)
//   d     in  : data byte
//   acc   out : current XOR of folded bytes
`ifdef UNPACK_CHECKSUM_EN
module byte_xor_acc
    import word_unpacker_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [BYTE_W-1:0] d,
    output logic [BYTE_W-1:0] acc
);

    logic [BYTE_W-1:0]           acc_q;
    logic [BYTE_W-1:0]           acc_d;
    logic [MAX_BYTES*BYTE_W-1:0] pair;

    always_comb begin
        pair  = '0;
        pair[2*BYTE_W-1:0] = {acc_q, d};
        acc_d = acc_q;
        // clr wins: a word is never accepted in the same cycle a byte moves
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = xor_bytes(pair);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule
`endif

// File: rtl/word_unpacker.sv
// word_unpacker
//   Accepts a packed WORD_BYTES-byte word and emits it MSB byte first as a
//   byte stream. Build option UNPACK_CHECKSUM_EN appends one XOR checksum
//   byte after the data bytes and moves out_last onto it.
//   Handshake (both sides): a transfer happens on a rising edge where
//   valid && ready; the producer holds data stable and never withdraws valid
//   until that transfer (reset excepted).
//   clk       in  : system clock, rising edge
//   rst_n     in  : synchronous reset, active-low
//   in_valid  in  : in_data holds a word
//   in_ready  out : unpacker idle and able to take a word
//   in_data   in  : packed word, byte WORD_BYTES-1 in the top 8 bits
//   out_valid out : out_data holds a byte
//   out_ready in  : sink takes the byte this cycle
//   out_data  out : current byte (00 when no byte is offered)
//   out_last  out : current byte is the final byte of the word
module word_unpacker
    import word_unpacker_pkg::*;
#(
    parameter int WORD_BYTES = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WORD_BYTES*BYTE_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BYTE_W-1:0]            out_data,
    output logic                         out_last
);

    localparam int          W        = WORD_BYTES * BYTE_W;
    localparam logic [2:0]  CNT_INIT = 3'(WORD_BYTES - 1);

    unpack_state_t state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [2:0]    cnt_q, cnt_d;

    logic accept;
    logic xfer;

    assign accept = (state_q == IDLE) && in_valid;
    assign xfer   = (state_q != IDLE) && out_ready;

`ifdef UNPACK_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;

    byte_xor_acc u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (xfer && (state_q == SEND)),
        .d     (shift_q[W-1 -: BYTE_W]),
        .acc   (csum)
    );
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = in_data;
                    cnt_d   = CNT_INIT;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    shift_d = shift_q << BYTE_W;
                    cnt_d   = cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
`ifdef UNPACK_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef UNPACK_CHECKSUM_EN
            CSUM: begin
                if (xfer) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // in_ready is also masked by rst_n so it reads 0 for the whole reset.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q != IDLE);

    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        if (state_q == SEND) begin
            out_data = shift_q[W-1 -: BYTE_W];
`ifndef UNPACK_CHECKSUM_EN
            out_last = (cnt_q == 3'd0);
`endif
        end
`ifdef UNPACK_CHECKSUM_EN
        if (state_q == CSUM) begin
            out_data = csum;
            out_last = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_word_unpacker.sv
module tb_word_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef UNPACK_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [23:0] in_data;
    logic [7:0]  out_data;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_last8;
    logic [63:0] in_data8;
    logic [7:0]  out_data8;

    word_unpacker #(.WORD_BYTES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    word_unpacker #(.WORD_BYTES(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_data(out_data8), .out_last(out_last8)
    );

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] exp8_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected stream for a word: bytes MSB first, last flag on the final
    // data byte, or on a trailing XOR byte when the checksum is built in.
    task automatic push_word(input logic [63:0] w, input int n, input bit wide);
        logic [7:0] b;
        logic [7:0] x;
        logic [8:0] e;
        x = 8'h00;
        for (int i = n - 1; i >= 0; i--) begin
            b = w[i*8 +: 8];
            x = x ^ b;
            e = {(i == 0) && !CK, b};
            if (wide) exp8_q.push_back(e);
            else      exp_q.push_back(e);
        end
        if (CK) begin
            e = {1'b1, x};
            if (wide) exp8_q.push_back(e);
            else      exp_q.push_back(e);
        end
    endtask

    // Monitor for the 3-byte instance: transfer order, stall stability,
    // in_ready low while busy and high right after the last byte.
    logic       prev_stall = 1'b0;
    logic       prev_last  = 1'b0;
    logic [8:0] prev_out   = '0;

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_last  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_last, out_data}, prev_out);
            end
            if (out_valid) check("busy_in_ready", in_ready, 0);
            if (prev_last) check("ready_after_last", in_ready, 1);
            prev_last = out_valid && out_ready && out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %h want none at %0t", {out_last, out_data}, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", {out_last, out_data}, e);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_last, out_data};
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && out_valid8 && out_ready8) begin
            if (exp8_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte8: got %h want none at %0t", {out_last8, out_data8}, $time);
            end else begin
                e = exp8_q.pop_front();
                check("byte8", {out_last8, out_data8}, e);
            end
        end
    end

    // Presents a word and returns just after the edge that accepted it,
    // leaving in_valid high so the caller can chain words back to back.
    task automatic send_word(input logic [23:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", in_ready, 1);
        if (in_ready) push_word({40'h0, w}, 3, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_word8(input logic [63:0] w);
        int n;
        n = 0;
        in_valid8 = 1'b1;
        in_data8  = w;
        @(negedge clk);
        while (!in_ready8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept8", in_ready8, 1);
        if (in_ready8) push_word(w, 8, 1'b1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp8_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain", exp_q.size() + exp8_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [4:0] pat;

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        in_data8   = '0;
        out_ready8 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_valid8", out_valid8, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 1);

        // single word, sink always ready
        send_word(24'h5CA5A5);
        in_valid = 1'b0;
        drain();

        // same word, sink stalls twice mid-word
        send_word(24'h5CA5A5);
        in_valid = 1'b0;
        pat = 5'b11001;
        for (int i = 4; i >= 0; i--) begin
            out_ready = pat[i];
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // back-to-back words with in_valid held high
        send_word(24'h010203);
        send_word(24'hFFEEDD);
        in_valid = 1'b0;
        drain();

        // reset after the first byte discards the rest of the word
        send_word(24'h112233);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_last", out_last, 0);
        check("midrst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(24'h445566);
        in_valid = 1'b0;
        drain();

        // XOR-cancelling word (checksum 00 when enabled)
        send_word(24'hFF0FF0);
        in_valid = 1'b0;
        drain();

        // widest configuration
        send_word8(64'h0123456789ABCDEF);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
